// File: rtl/fp_wb_merge_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_merge_arbiter_pkg
// Brief    : Shared types and helpers for the FP intermediate writeback merge
//            arbiter: payload struct, GRS width, sticky collapse helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fp_wb_merge_arbiter_pkg;

    localparam int GRS_WIDTH       = 8;
    localparam int FP_WB_MAX_UNITS = 8;

    typedef struct packed {
        logic [5:0]           id;
        logic [4:0]           rd;
        logic [4:0]           fflags;
        logic [2:0]           rm;
        logic [GRS_WIDTH-1:0] grs;
        logic [5:0]           clz;
        logic [5:0]           shift;
        logic [3:0]           flags;
    } fp_wb_payload_t;

    // Keep the top 'keep' GRS bits, fold every bit below them into one sticky
    // bit directly underneath, zero the rest. keep = GRS_WIDTH-1 is a plain copy.
    function automatic logic [GRS_WIDTH-1:0] fp_collapse_grs(
        input logic [GRS_WIDTH-1:0] grs,
        input int                   keep
    );
        logic [GRS_WIDTH-1:0] res;
        logic                 sticky;
        res    = '0;
        sticky = 1'b0;
        for (int i = 0; i < GRS_WIDTH; i++) begin
            sticky = sticky | grs[i];
            if (i > GRS_WIDTH - 1 - keep) begin
                res[i] = grs[i];
            end else if (i == GRS_WIDTH - 1 - keep) begin
                res[i] = sticky;
            end
        end
        return res;
    endfunction

    // Payload with only the GRS field narrowed; all other fields pass through.
    function automatic fp_wb_payload_t fp_collapse_payload(
        input fp_wb_payload_t p,
        input int             keep
    );
        fp_wb_payload_t r;
        r     = p;
        r.grs = fp_collapse_grs(p.grs, keep);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_wb_merge_arbiter_grant_sel.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_merge_arbiter_grant_sel
// Brief    : Combinational one-hot grant selection. Fixed priority (highest
//            index wins, starved units override, lowest starved index first)
//            or round-robin starting at the pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fp_wb_merge_arbiter_grant_sel #(
    parameter int NUM_UNITS = 2,
    parameter int ARB_RR    = 0,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_UNITS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    input  logic [NUM_UNITS-1:0] i_starved,
    output logic [NUM_UNITS-1:0] o_grant
);

    localparam logic [NUM_UNITS-1:0] c_one = {{(NUM_UNITS-1){1'b0}}, 1'b1};

    int w_idx;

    // Pick exactly one requester; later loop iterations override earlier ones
    always_comb begin
        o_grant = '0;
        w_idx   = 0;
        if (ARB_RR != 0) begin
            for (int k = NUM_UNITS - 1; k >= 0; k--) begin
                w_idx = (int'(i_ptr) + k) % NUM_UNITS;
                if ((i_req >> w_idx) & c_one) begin
                    o_grant = c_one << w_idx;
                end
            end
        end else if ((i_req & i_starved) != '0) begin
            for (int j = NUM_UNITS - 1; j >= 0; j--) begin
                if (i_req[j] & i_starved[j]) begin
                    o_grant = c_one << j;
                end
            end
        end else begin
            for (int j = 0; j < NUM_UNITS; j++) begin
                if (i_req[j]) begin
                    o_grant = c_one << j;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_wb_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_merge_arbiter
// Brief    : N-way merge of FP intermediate writeback streams into a single
//            registered output slot with per-unit GRS sticky collapse.
//            Optional anti-starvation ageing for fixed priority is enabled
//            by defining FP_WB_MERGE_AGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_wb_merge_arbiter
    import fp_wb_merge_arbiter_pkg::*;
#(
    parameter int                            NUM_UNITS    = 2,
    parameter int                            ARB_RR       = 0,
    parameter logic [4*FP_WB_MAX_UNITS-1:0]  STICKY_KEEP  = 32'h7777_7732,
    parameter int                            STARVE_LIMIT = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_UNITS-1:0]             i_unit_done,
    input  fp_wb_payload_t [NUM_UNITS-1:0]   i_unit_wb,
    output logic [NUM_UNITS-1:0]             o_unit_ack,
    output logic                             o_wb_done,
    output fp_wb_payload_t                   o_wb,
    input  logic                             i_wb_ack
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                  r_run;
    logic                  r_wb_done;
    fp_wb_payload_t        r_wb;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_free;
    logic [NUM_UNITS-1:0]  w_req;
    logic [NUM_UNITS-1:0]  w_grant;
    logic [NUM_UNITS-1:0]  w_starved;
    fp_wb_payload_t        w_mux;

    // Reset release takes effect on a clock edge so no grant races the release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_free = r_run & (~r_wb_done | i_wb_ack);
    assign w_req  = i_unit_done & {NUM_UNITS{w_free}};

    fp_wb_merge_arbiter_grant_sel #(
        .NUM_UNITS (NUM_UNITS),
        .ARB_RR    (ARB_RR),
        .PTR_W     (PTR_W)
    ) u_grant_sel (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .i_starved (w_starved),
        .o_grant   (w_grant)
    );

    assign o_unit_ack = w_grant;

    // One-hot AND-OR payload mux over the sticky-collapsed unit payloads
    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_mux = w_mux | (fp_collapse_payload(i_unit_wb[i], int'(STICKY_KEEP[4*i +: 4]))
                             & {$bits(fp_wb_payload_t){w_grant[i]}});
        end
    end

    // Output slot: refill on grant, empty when consumed without a new grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_done <= 1'b0;
            r_wb      <= '0;
        end else if (w_free) begin
            r_wb_done <= |w_grant;
            if (|w_grant) begin
                r_wb <= w_mux;
            end
        end
    end

    assign o_wb_done = r_wb_done;
    assign o_wb      = r_wb;

    // Round-robin pointer moves just past the winner; held when nothing granted
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_grant[i]) begin
                w_ptr_nxt = PTR_W'((i + 1) % NUM_UNITS);
            end
        end
    end

    // Pointer register (only consulted by the round-robin selector)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

`ifdef FP_WB_MERGE_AGE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    if (ARB_RR == 0) begin : g_age
        logic [NUM_UNITS-1:0][CNT_W-1:0] r_starve_cnt;

        // Count consecutive lost arbitrations; saturate at the limit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_starve_cnt <= '0;
            end else begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (!i_unit_done[i] || w_grant[i]) begin
                        r_starve_cnt[i] <= '0;
                    end else if (w_free && (r_starve_cnt[i] < CNT_W'(STARVE_LIMIT))) begin
                        r_starve_cnt[i] <= r_starve_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end

        // A unit at the limit overrides plain fixed priority
        always_comb begin
            w_starved = '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                w_starved[i] = (r_starve_cnt[i] >= CNT_W'(STARVE_LIMIT));
            end
        end
    end else begin : g_no_age
        assign w_starved = '0;
    end
`else
    assign w_starved = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_wb_merge_arbiter
// Brief    : Self-checking bench: a 2-unit fixed-priority instance and a
//            4-unit round-robin instance, directed scenarios plus randomized
//            traffic checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_wb_merge_arbiter;
    import fp_wb_merge_arbiter_pkg::*;

    localparam int          NA     = 2;
    localparam int          NB     = 4;
    localparam int          LIMIT  = 3;
    localparam logic [31:0] KEEP_A = 32'h7777_7732;
    localparam logic [31:0] KEEP_B = 32'h7777_7352;
`ifdef FP_WB_MERGE_AGE_EN
    localparam bit          AGE    = 1'b1;
`else
    localparam bit          AGE    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA-1:0]           a_done;
    fp_wb_payload_t [NA-1:0] a_in;
    logic [NA-1:0]           a_ack;
    logic                    a_wb_done;
    fp_wb_payload_t          a_wb;
    logic                    a_wb_ack;

    logic [NB-1:0]           b_done;
    fp_wb_payload_t [NB-1:0] b_in;
    logic [NB-1:0]           b_ack;
    logic                    b_wb_done;
    fp_wb_payload_t          b_wb;
    logic                    b_wb_ack;

    fp_wb_merge_arbiter #(.NUM_UNITS(NA), .ARB_RR(0), .STICKY_KEEP(KEEP_A), .STARVE_LIMIT(LIMIT)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_unit_done(a_done), .i_unit_wb(a_in), .o_unit_ack(a_ack),
        .o_wb_done(a_wb_done), .o_wb(a_wb), .i_wb_ack(a_wb_ack));

    fp_wb_merge_arbiter #(.NUM_UNITS(NB), .ARB_RR(1), .STICKY_KEEP(KEEP_B), .STARVE_LIMIT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_unit_done(b_done), .i_unit_wb(b_in), .o_unit_ack(b_ack),
        .o_wb_done(b_wb_done), .o_wb(b_wb), .i_wb_ack(b_wb_ack));

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit             m_run;
    bit             ma_valid;
    fp_wb_payload_t ma_pay;
    int             ma_cnt [NA];
    bit             mb_valid;
    fp_wb_payload_t mb_pay;
    int             mb_ptr;

    function automatic int keep_of(input logic [31:0] keep, input int u);
        return int'(keep[4*u +: 4]);
    endfunction

    // Top k bits kept, sticky = (remaining low bits != 0) placed just below
    function automatic logic [7:0] ref_grs(input logic [7:0] grs, input int k);
        int low, hi_part, rest, res;
        low     = GRS_WIDTH - k;
        hi_part = (int'(grs) >> low) << low;
        rest    = int'(grs) % (1 << low);
        res     = hi_part + ((rest != 0) ? (1 << (low - 1)) : 0);
        return res[7:0];
    endfunction

    function automatic fp_wb_payload_t ref_pay(input fp_wb_payload_t p, input int k);
        fp_wb_payload_t r;
        r     = p;
        r.grs = ref_grs(p.grs, k);
        return r;
    endfunction

    function automatic fp_wb_payload_t rand_pay();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[$bits(fp_wb_payload_t)-1:0];
    endfunction

    function automatic logic [7:0] onehot(input int g);
        return (g < 0) ? 8'h00 : (8'h01 << g);
    endfunction

    function automatic int ref_grant_a();
        if (!rst_n || !m_run || (ma_valid && !a_wb_ack)) return -1;
        if (AGE) begin
            for (int u = 0; u < NA; u++) if (a_done[u] && ma_cnt[u] >= LIMIT) return u;
        end
        for (int u = NA - 1; u >= 0; u--) if (a_done[u]) return u;
        return -1;
    endfunction

    function automatic int ref_grant_b();
        if (!rst_n || !m_run || (mb_valid && !b_wb_ack)) return -1;
        for (int k = 0; k < NB; k++) if (b_done[(mb_ptr + k) % NB]) return (mb_ptr + k) % NB;
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; ma_valid = 0; ma_pay = '0; mb_valid = 0; mb_pay = '0; mb_ptr = 0;
        for (int u = 0; u < NA; u++) ma_cnt[u] = 0;
    endtask

    task automatic model_update(input int ga, input int gb);
        bit fa, fb;
        fa = m_run && (!ma_valid || a_wb_ack);
        fb = m_run && (!mb_valid || b_wb_ack);
        for (int u = 0; u < NA; u++) begin
            if (!a_done[u] || ga == u) ma_cnt[u] = 0;
            else if (fa)               ma_cnt[u] = (ma_cnt[u] + 1 > LIMIT) ? LIMIT : ma_cnt[u] + 1;
        end
        if (fa) begin
            ma_valid = (ga >= 0);
            if (ga >= 0) ma_pay = ref_pay(a_in[ga], keep_of(KEEP_A, ga));
        end
        if (fb) begin
            mb_valid = (gb >= 0);
            if (gb >= 0) begin
                mb_pay = ref_pay(b_in[gb], keep_of(KEEP_B, gb));
                mb_ptr = (gb + 1) % NB;
            end
        end
        m_run = 1;
    endtask

    // One clock: model follows the edge; granted units optionally drop done
    task automatic tick(input bit drop);
        int ga, gb;
        ga = ref_grant_a();
        gb = ref_grant_b();
        @(posedge clk);
        model_update(ga, gb);
        #1;
        if (drop && ga >= 0) a_done[ga] = 1'b0;
        if (drop && gb >= 0) b_done[gb] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_done = '0; b_done = '0; a_wb_ack = 1'b0; b_wb_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 m_run = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; a_done = 2'b11; b_done = 4'hF; a_wb_ack = 1'b1; b_wb_ack = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_ack !== 2'b00) begin errors++; $display("FAIL reset_a_ack: got %b want 00", a_ack); end
        checks++; if (b_ack !== 4'h0) begin errors++; $display("FAIL reset_b_ack: got %b want 0000", b_ack); end
        checks++; if (a_wb_done !== 1'b0) begin errors++; $display("FAIL reset_a_done: got %b want 0", a_wb_done); end
        checks++; if (b_wb_done !== 1'b0) begin errors++; $display("FAIL reset_b_done: got %b want 0", b_wb_done); end
        checks++; if (a_wb !== '0) begin errors++; $display("FAIL reset_a_wb: got %h want 0", a_wb); end
        checks++; if (b_wb !== '0) begin errors++; $display("FAIL reset_b_wb: got %h want 0", b_wb); end
    endtask

    task automatic test_fixed_pair();
        logic [1:0] exp_ack  [3] = '{2'b10, 2'b01, 2'b00};
        logic [5:0] exp_id   [3] = '{6'h00, 6'h0B, 6'h0A};
        logic       exp_done [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        a_in[0] = rand_pay(); a_in[0].id = 6'h0A;
        a_in[1] = rand_pay(); a_in[1].id = 6'h0B;
        a_done = 2'b11; a_wb_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_ack !== exp_ack[i]) begin errors++; $display("FAIL fixed_ack[%0d]: got %b want %b", i, a_ack, exp_ack[i]); end
            checks++; if (a_wb_done !== exp_done[i]) begin errors++; $display("FAIL fixed_done[%0d]: got %b want %b", i, a_wb_done, exp_done[i]); end
            if (i > 0) begin
                checks++; if (a_wb.id !== exp_id[i]) begin errors++; $display("FAIL fixed_id[%0d]: got %h want %h", i, a_wb.id, exp_id[i]); end
            end
            tick(1'b1);
        end
    endtask

    task automatic test_rr();
        logic [3:0] e;
        logic [5:0] eid;
        do_reset();
        for (int u = 0; u < NB; u++) begin b_in[u] = rand_pay(); b_in[u].id = 6'(16 + u); end
        b_done = 4'hF; b_wb_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = 4'(1 << (i % 4));
            checks++; if (b_ack !== e) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, b_ack, e); end
            if (i > 0) begin
                eid = 6'(16 + (i - 1) % 4);
                checks++; if (b_wb_done !== 1'b1) begin errors++; $display("FAIL rr_done[%0d]: got %b want 1", i, b_wb_done); end
                checks++; if (b_wb.id !== eid) begin errors++; $display("FAIL rr_id[%0d]: got %h want %h", i, b_wb.id, eid); end
                checks++; if (b_wb !== mb_pay) begin errors++; $display("FAIL rr_wb[%0d]: got %h want %h", i, b_wb, mb_pay); end
            end
            tick(1'b0);
        end
    endtask

    task automatic test_backpressure();
        fp_wb_payload_t exp0, exp1;
        do_reset();
        a_in[0] = rand_pay(); a_in[1] = rand_pay();
        exp0 = ref_pay(a_in[0], 2); exp1 = ref_pay(a_in[1], 3);
        a_done = 2'b01; a_wb_ack = 1'b0;
        @(negedge clk);
        checks++; if (a_ack !== 2'b01) begin errors++; $display("FAIL bp_first_ack: got %b want 01", a_ack); end
        tick(1'b1);
        a_done = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_ack !== 2'b00) begin errors++; $display("FAIL bp_hold_ack[%0d]: got %b want 00", i, a_ack); end
            checks++; if (a_wb_done !== 1'b1) begin errors++; $display("FAIL bp_hold_done[%0d]: got %b want 1", i, a_wb_done); end
            checks++; if (a_wb !== exp0) begin errors++; $display("FAIL bp_hold_wb[%0d]: got %h want %h", i, a_wb, exp0); end
            tick(1'b1);
        end
        a_wb_ack = 1'b1;
        @(negedge clk);
        checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL bp_release_ack: got %b want 10", a_ack); end
        tick(1'b1);
        a_wb_ack = 1'b0;
        @(negedge clk);
        checks++; if (a_wb_done !== 1'b1) begin errors++; $display("FAIL bp_next_done: got %b want 1", a_wb_done); end
        checks++; if (a_wb !== exp1) begin errors++; $display("FAIL bp_next_wb: got %h want %h", a_wb, exp1); end
    endtask

    task automatic test_sticky();
        logic [7:0] gin  [4] = '{8'b1100_0001, 8'b1100_0000, 8'b1010_0100, 8'b1010_0000};
        logic [7:0] gexp [4] = '{8'b1110_0000, 8'b1100_0000, 8'b1011_0000, 8'b1010_0000};
        int         unit [4] = '{0, 0, 1, 1};
        fp_wb_payload_t p, e;
        do_reset();
        a_wb_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p = rand_pay(); p.grs = gin[i];
            a_in[unit[i]] = p;
            a_done = (unit[i] == 0) ? 2'b01 : 2'b10;
            tick(1'b1);
            @(negedge clk);
            e = p; e.grs = gexp[i];
            checks++; if (a_wb.grs !== gexp[i]) begin errors++; $display("FAIL sticky_grs[%0d]: got %b want %b", i, a_wb.grs, gexp[i]); end
            checks++; if (a_wb !== e) begin errors++; $display("FAIL sticky_wb[%0d]: got %h want %h", i, a_wb, e); end
        end
    endtask

`ifdef FP_WB_MERGE_AGE_EN
    task automatic test_age();
        logic [1:0] exp_ack [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset();
        a_in[0] = rand_pay(); a_in[1] = rand_pay();
        a_done = 2'b11; a_wb_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_ack !== exp_ack[i]) begin errors++; $display("FAIL age_ack[%0d]: got %b want %b", i, a_ack, exp_ack[i]); end
            tick(1'b0);
        end
    endtask
`endif

    task automatic test_async_reset();
        fp_wb_payload_t exp1;
        do_reset();
        a_in[0] = rand_pay(); a_in[1] = rand_pay();
        exp1 = ref_pay(a_in[1], 3);
        a_done = 2'b01; a_wb_ack = 1'b0;
        @(negedge clk);
        checks++; if (a_ack !== 2'b01) begin errors++; $display("FAIL arst_first_ack: got %b want 01", a_ack); end
        tick(1'b1);
        a_done = 2'b10;
        @(negedge clk);
        checks++; if (a_wb_done !== 1'b1) begin errors++; $display("FAIL arst_full: got %b want 1", a_wb_done); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_wb_done !== 1'b0) begin errors++; $display("FAIL arst_drop_done: got %b want 0", a_wb_done); end
        checks++; if (a_ack !== 2'b00) begin errors++; $display("FAIL arst_ack: got %b want 00", a_ack); end
        checks++; if (a_wb !== '0) begin errors++; $display("FAIL arst_wb: got %h want 0", a_wb); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 m_run = 1;
        @(negedge clk);
        checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL arst_regrant: got %b want 10", a_ack); end
        tick(1'b1);
        @(negedge clk);
        checks++; if (a_wb_done !== 1'b1) begin errors++; $display("FAIL arst_after_done: got %b want 1", a_wb_done); end
        checks++; if (a_wb !== exp1) begin errors++; $display("FAIL arst_after_wb: got %h want %h", a_wb, exp1); end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            a_wb_ack = ($urandom_range(0, 9) < 6);
            b_wb_ack = ($urandom_range(0, 9) < 6);
            for (int u = 0; u < NA; u++) if (!a_done[u] && $urandom_range(0, 9) < 4) begin a_in[u] = rand_pay(); a_done[u] = 1'b1; end
            for (int u = 0; u < NB; u++) if (!b_done[u] && $urandom_range(0, 9) < 4) begin b_in[u] = rand_pay(); b_done[u] = 1'b1; end
            @(negedge clk);
            ea = onehot(ref_grant_a());
            eb = onehot(ref_grant_b());
            checks++; if (a_ack !== ea[NA-1:0]) begin errors++; $display("FAIL rand_a_ack[%0d]: got %b want %b", c, a_ack, ea[NA-1:0]); end
            checks++; if (b_ack !== eb[NB-1:0]) begin errors++; $display("FAIL rand_b_ack[%0d]: got %b want %b", c, b_ack, eb[NB-1:0]); end
            checks++; if (a_wb_done !== ma_valid) begin errors++; $display("FAIL rand_a_done[%0d]: got %b want %b", c, a_wb_done, ma_valid); end
            checks++; if (b_wb_done !== mb_valid) begin errors++; $display("FAIL rand_b_done[%0d]: got %b want %b", c, b_wb_done, mb_valid); end
            checks++; if (a_wb !== ma_pay) begin errors++; $display("FAIL rand_a_wb[%0d]: got %h want %h", c, a_wb, ma_pay); end
            checks++; if (b_wb !== mb_pay) begin errors++; $display("FAIL rand_b_wb[%0d]: got %h want %h", c, b_wb, mb_pay); end
            tick(1'b1);
        end
    endtask

    initial begin
        a_done = '0; b_done = '0; a_in = '0; b_in = '0; a_wb_ack = 1'b0; b_wb_ack = 1'b0;
        test_reset();
        test_fixed_pair();
        test_rr();
        test_backpressure();
        test_sticky();
`ifdef FP_WB_MERGE_AGE_EN
        test_age();
`endif
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
